// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between the in-order WB stage and a long-latency unit via a one-entry hold buffer.
// Latency: WB writes the same cycle; an accepted LU result writes 1 cycle later at the earliest.
// Backpressure: lu_ready drops while a held result waits; wb_stall is raised for one forced cycle per LU result.
module rf_wport_arbiter #(
    parameter int WIDTH        = 32,
    parameter int RADDR        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [WIDTH-1:0] wb_pc,
    input  logic [RADDR-1:0] wb_waddr,
    input  logic [WIDTH-1:0] wb_wdata,
    output logic             wb_stall,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [WIDTH-1:0] lu_pc,
    input  logic [RADDR-1:0] lu_waddr,
    input  logic [WIDTH-1:0] lu_wdata,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             pend_valid,
    output logic [RADDR-1:0] pend_waddr,
    output logic [WIDTH-1:0] debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [RADDR-1:0] debug_wb_rf_wnum,
    output logic [WIDTH-1:0] debug_wb_rf_wdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("rf_wport_arbiter: STARVE_LIMIT must be within 1..15");
    end

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [RADDR-1:0] waddr;
        logic [WIDTH-1:0] wdata;
    } hold_t;

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    hold_t      hold_q, hold_d;

    logic pend_grant;
    logic wb_grant;
    logic lu_accept;

    // Write-port mux and handshakes: purely a function of current state and inputs.
    always_comb begin
        pend_grant = (state_q == FORCE) || ((state_q == HELD) && !wb_valid);
        wb_grant   = wb_valid && !pend_grant;
        wb_stall   = wb_valid && pend_grant;
        lu_ready   = (state_q == EMPTY) || pend_grant;
        lu_accept  = lu_valid && lu_ready;

        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        debug_wb_pc = '0;
        if (pend_grant) begin
            rf_we       = 1'b1;
            rf_waddr    = hold_q.waddr;
            rf_wdata    = hold_q.wdata;
            debug_wb_pc = hold_q.pc;
        end else if (wb_grant) begin
            rf_we       = 1'b1;
            rf_waddr    = wb_waddr;
            rf_wdata    = wb_wdata;
            debug_wb_pc = wb_pc;
        end

        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;

        pend_valid = (state_q != EMPTY);
        pend_waddr = pend_valid ? hold_q.waddr : '0;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        hold_d       = hold_q;

        // The hold register only loads on accept, so the entry being drained
        // this cycle is still what drives the port above.
        if (lu_accept) begin
            hold_d = '{pc: lu_pc, waddr: lu_waddr, wdata: lu_wdata};
        end

        case (state_q)
            EMPTY: begin
                if (lu_accept) begin
                    state_d      = HELD;
                    starve_cnt_d = '0;
                end
            end
            HELD: begin
                if (pend_grant) begin
                    if (lu_accept) begin
                        state_d      = HELD;
                        starve_cnt_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end else begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                    if (starve_cnt_q + 4'd1 == LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (lu_accept) begin
                    state_d      = HELD;
                    starve_cnt_d = '0;
                end else begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d      = EMPTY;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            starve_cnt_q <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench: stimulus pushes expected RF writes into a scoreboard queue, a monitor pops them on rf_we.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [31:0] lu_pc;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_waddr;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    rf_wport_arbiter #(.WIDTH(32), .RADDR(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_pc(lu_pc), .lu_waddr(lu_waddr),
        .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_waddr(pend_waddr),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic mon_en   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every RF write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && rf_we !== 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(rf_waddr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_rf_we", 32'(rf_we), 32'd1);
                chk("sb_waddr", 32'(rf_waddr), 32'(e.waddr));
                chk("sb_wdata", rf_wdata, e.wdata);
                chk("sb_pc", debug_wb_pc, e.pc);
                chk("sb_dbg_we", 32'(debug_wb_rf_we), 32'hF);
                chk("sb_dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.waddr));
                chk("sb_dbg_wdata", debug_wb_rf_wdata, e.wdata);
            end
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        e.waddr = a;
        e.wdata = d;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc);
        wb_valid = v;
        wb_waddr = a;
        wb_wdata = d;
        wb_pc    = pc;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc);
        lu_valid = v;
        lu_waddr = a;
        lu_wdata = d;
        lu_pc    = pc;
    endtask

    task automatic idle();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0);
        drive_lu(1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Status outputs for the current cycle, sampled mid-cycle.
    task automatic cyc(input string tag, input logic we, input logic stall, input logic lrdy,
                       input logic pv, input logic [4:0] pa);
        @(negedge clk);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, "_wb_stall"}, 32'(wb_stall), 32'(stall));
        chk({tag, "_lu_ready"}, 32'(lu_ready), 32'(lrdy));
        chk({tag, "_pend_valid"}, 32'(pend_valid), 32'(pv));
        chk({tag, "_pend_waddr"}, 32'(pend_waddr), 32'(pa));
    endtask

    initial begin
        reset = 1'b1;
        drive_wb(1'b1, 5'd1, 32'hAAAA, 32'h80);
        drive_lu(1'b1, 5'd2, 32'hBBBB, 32'h90);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset release: nothing was accepted while reset was high.
        idle();
        cyc("rst_idle", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        drive_wb(1'b1, 5'd1, 32'h11, 32'h100);
        push(5'd1, 32'h11, 32'h100);
        cyc("rst_wb", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);

        // Idle LU path: accept, write one cycle later, then empty.
        next_cycle();
        idle();
        drive_lu(1'b1, 5'd5, 32'h1234, 32'h200);
        cyc("lu_acc", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        idle();
        push(5'd5, 32'h1234, 32'h200);
        cyc("lu_ret", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        next_cycle();
        cyc("lu_done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);

        // WB priority over a held LU entry.
        next_cycle();
        drive_lu(1'b1, 5'd7, 32'h77, 32'h300);
        cyc("pri_acc", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_lu(1'b0, 5'd0, 32'd0, 32'd0);
            drive_wb(1'b1, 5'd3, 32'h30 + 32'(i), 32'h310 + 32'(4 * i));
            push(5'd3, 32'h30 + 32'(i), 32'h310 + 32'(4 * i));
            cyc("pri_wb", 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
        end
        next_cycle();
        idle();
        push(5'd7, 32'h77, 32'h300);
        cyc("pri_drain", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);

        // Starvation: four WB writes, one forced cycle, then the stalled WB write.
        next_cycle();
        drive_lu(1'b1, 5'd9, 32'h99, 32'h400);
        cyc("stv_acc", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_lu(1'b0, 5'd0, 32'd0, 32'd0);
            drive_wb(1'b1, 5'd4, 32'h40 + 32'(i), 32'h410 + 32'(4 * i));
            push(5'd4, 32'h40 + 32'(i), 32'h410 + 32'(4 * i));
            cyc("stv_wb", 1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
        end
        next_cycle();
        drive_wb(1'b1, 5'd4, 32'h44, 32'h420);
        push(5'd9, 32'h99, 32'h400);
        cyc("stv_force", 1'b1, 1'b1, 1'b1, 1'b1, 5'd9);
        next_cycle();
        push(5'd4, 32'h44, 32'h420);
        cyc("stv_retry", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);

        // Back-to-back LU results drain and refill in the same cycle.
        next_cycle();
        idle();
        drive_lu(1'b1, 5'd10, 32'hA0, 32'h500);
        cyc("b2b_0", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        drive_lu(1'b1, 5'd11, 32'hB0, 32'h504);
        push(5'd10, 32'hA0, 32'h500);
        cyc("b2b_1", 1'b1, 1'b0, 1'b1, 1'b1, 5'd10);
        next_cycle();
        drive_lu(1'b1, 5'd12, 32'hC0, 32'h508);
        push(5'd11, 32'hB0, 32'h504);
        cyc("b2b_2", 1'b1, 1'b0, 1'b1, 1'b1, 5'd11);
        next_cycle();
        idle();
        push(5'd12, 32'hC0, 32'h508);
        cyc("b2b_3", 1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
        next_cycle();
        cyc("b2b_done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);

        // Reset while the held entry is about to be forced: it must be discarded.
        next_cycle();
        drive_lu(1'b1, 5'd13, 32'hD0, 32'h600);
        cyc("mr_acc", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_lu(1'b0, 5'd0, 32'd0, 32'd0);
            drive_wb(1'b1, 5'd6, 32'h60 + 32'(i), 32'h610 + 32'(4 * i));
            push(5'd6, 32'h60 + 32'(i), 32'h610 + 32'(4 * i));
            if (i == 3) reset = 1'b1;
            cyc("mr_wb", 1'b1, 1'b0, 1'b0, 1'b1, 5'd13);
        end
        next_cycle();
        reset = 1'b0;
        drive_wb(1'b1, 5'd6, 32'h64, 32'h620);
        push(5'd6, 32'h64, 32'h620);
        cyc("mr_after", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        idle();
        cyc("mr_idle", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        next_cycle();
        cyc("mr_idle2", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
